// File: rtl/aes_pkg.sv
// Shared AES constants, the key-expansion Rcon table and the key-schedule FSM state type.
package aes_pkg;
  localparam int AES_KEY256_SIZE   = 256;
  localparam int AES_BLOCK_SIZE    = 128;
  localparam int AES_WORD_SIZE     = 32;
  localparam int AES256_ROUND_KEYS = 15;

  // AES-256 needs Rcon(1..7) only; each value sits in byte 0 of the word.
  localparam logic [7:0] AES_RCON [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} ks_state_t;
endpackage

// File: rtl/aes256_key_step.sv
// One combinational AES-256 key-expansion step: next round key from the two preceding ones.
module aes256_key_step
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_SIZE-1:0] prev,
  input  logic [AES_BLOCK_SIZE-1:0] cur,
  input  logic                      even,
  input  logic [7:0]                rcon,
  output logic [AES_BLOCK_SIZE-1:0] nxt
);
  logic [AES_WORD_SIZE-1:0] w3, sub_in, sub_out, t, n0, n1, n2, n3;

  assign w3 = cur[127:96];
  // Byte 0 lives in the low bits, so RotWord is a rotate right by one byte.
  assign sub_in = even ? {w3[7:0], w3[31:8]} : w3;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.din(sub_in[8*b +: 8]), .dout(sub_out[8*b +: 8]));
  end

  assign t  = sub_out ^ {24'h0, (even ? rcon : 8'h00)};
  assign n0 = prev[31:0]   ^ t;
  assign n1 = prev[63:32]  ^ n0;
  assign n2 = prev[95:64]  ^ n1;
  assign n3 = prev[127:96] ^ n2;
  assign nxt = {n3, n2, n1, n0};
endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box as a combinational lookup table.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  assign dout = SBOX[din];
endmodule

// File: rtl/aes256_key_schedule.sv
// Sequential AES-256 key schedule: one round key per clock into 15x128 storage, random-access read.
// Optional zeroize (key_clear port, storage reset) is enabled by defining AES_KEY_ZEROIZE_EN.
module aes256_key_schedule
  import aes_pkg::*;
#(
  parameter int RK_READ_REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [255:0] key,
  output logic         busy,
  output logic         rk_valid,
  input  logic [3:0]   rk_addr,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic         key_clear,
`endif
  output logic [127:0] rk_data
);
  localparam logic [3:0] LAST_RK = 4'(AES256_ROUND_KEYS - 1);

  ks_state_t state, state_nxt;
  logic [3:0] rnd, rnd_nxt;
  logic [AES_BLOCK_SIZE-1:0] rk_mem [AES256_ROUND_KEYS];
  logic [AES_BLOCK_SIZE-1:0] rk_nxt, rd_data;
  logic clr, ld, step;

`ifdef AES_KEY_ZEROIZE_EN
  assign clr = key_clear;
`else
  assign clr = 1'b0;
`endif

  assign busy      = (state == EXPAND);
  assign rk_valid  = (state == DONE);
  assign key_ready = !busy && !clr;
  assign ld        = key_valid && key_ready;
  assign step      = busy && !clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rnd   <= '0;
    end else begin
      state <= state_nxt;
      rnd   <= rnd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rnd_nxt   = rnd;
    case (state)
      IDLE, DONE: if (ld) begin
        state_nxt = EXPAND;
        rnd_nxt   = 4'd2;
      end
      EXPAND: begin
        rnd_nxt = rnd + 4'd1;
        if (rnd == LAST_RK) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clr) begin
      state_nxt = IDLE;
      rnd_nxt   = '0;
    end
  end

  aes256_key_step u_step (
    .prev (rk_mem[rnd - 4'd2]),
    .cur  (rk_mem[rnd - 4'd1]),
    .even (!rnd[0]),
    .rcon (AES_RCON[rnd[3:1]]),
    .nxt  (rk_nxt)
  );

`ifdef AES_KEY_ZEROIZE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < AES256_ROUND_KEYS; i++) rk_mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < AES256_ROUND_KEYS; i++) rk_mem[i] <= '0;
    end else if (ld) begin
      rk_mem[0] <= key[127:0];
      rk_mem[1] <= key[255:128];
    end else if (step) begin
      rk_mem[rnd] <= rk_nxt;
    end
  end
`else
  // Key material is overwritten on every load, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (ld) begin
      rk_mem[0] <= key[127:0];
      rk_mem[1] <= key[255:128];
    end else if (step) begin
      rk_mem[rnd] <= rk_nxt;
    end
  end
`endif

  assign rd_data = (rk_addr <= LAST_RK) ? rk_mem[rk_addr] : '0;

  if (RK_READ_REG != 0) begin : g_rd_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rk_data <= '0;
      else     rk_data <= rd_data;
    end
  end else begin : g_rd_comb
    assign rk_data = rd_data;
  end
endmodule

// File: tb/tb_aes256_key_schedule.sv
// Directed bench: FIPS-197 and all-zero key vectors, stall, reset abort, read latency for both read variants.
module tb_aes256_key_schedule;
  logic clk = 1'b0, rst = 1'b1, key_valid = 1'b0;
  logic [255:0] key = '0;
  logic [3:0] rk_addr = '0;
  logic key_ready_r, busy_r, rk_valid_r, key_ready_c, busy_c, rk_valid_c;
  logic [127:0] rk_data_r, rk_data_c;
`ifdef AES_KEY_ZEROIZE_EN
  logic key_clear = 1'b0;
`endif
  int n_chk = 0, n_fail = 0;

  logic [255:0] key_a;
  logic [127:0] a_rk0, a_rk1, a_rk2, a_rk14, z_rk2, z_rk3;

  always #5 clk = ~clk;

  aes256_key_schedule #(.RK_READ_REG(1)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready_r), .key(key),
    .busy(busy_r), .rk_valid(rk_valid_r), .rk_addr(rk_addr),
`ifdef AES_KEY_ZEROIZE_EN
    .key_clear(key_clear),
`endif
    .rk_data(rk_data_r)
  );

  aes256_key_schedule #(.RK_READ_REG(0)) dut_c (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready_c), .key(key),
    .busy(busy_c), .rk_valid(rk_valid_c), .rk_addr(rk_addr),
`ifdef AES_KEY_ZEROIZE_EN
    .key_clear(key_clear),
`endif
    .rk_data(rk_data_c)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected values are written in FIPS byte order (byte 0 leftmost); swap to bus order.
  function automatic logic [127:0] bsw(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = x[8*(15-i) +: 8];
    return r;
  endfunction

  // Called 1 time unit after a rising edge; returns there too.
  task automatic load(input logic [255:0] k);
    key = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("accept_busy", 128'(busy_r), 128'(1'b1));
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!rk_valid_r && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic rd(input logic [3:0] a, input logic [127:0] exp, input string tag);
    rk_addr = a;
    #1;
    chk({tag, "_comb"}, rk_data_c, exp);
    @(posedge clk); #1;
    chk({tag, "_reg"}, rk_data_r, exp);
  endtask

  initial begin
    int n;
    logic stall_ok;
    for (int i = 0; i < 32; i++) key_a[8*i +: 8] = 8'(i);
    a_rk0  = bsw(128'h000102030405060708090a0b0c0d0e0f);
    a_rk1  = bsw(128'h101112131415161718191a1b1c1d1e1f);
    a_rk2  = bsw(128'ha573c29fa176c498a97fce93a572c09c);
    a_rk14 = bsw(128'h24fc79ccbf0979e9371ac23c6d68de36);
    z_rk2  = bsw(128'h62636363626363636263636362636363);
    z_rk3  = bsw(128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);

    #12;
    chk("rst_busy", 128'(busy_r), 128'(1'b0));
    chk("rst_valid", 128'(rk_valid_r), 128'(1'b0));
    chk("rst_ready", 128'(key_ready_r), 128'(1'b1));
    chk("rst_rk_data", rk_data_r, '0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Zero key loaded, FIPS key held on the bus for the whole expansion.
    rk_addr = 4'd2;
    load('0);
    chk("accept_valid_low", 128'(rk_valid_r), 128'(1'b0));
    key = key_a;
    key_valid = 1'b1;
    stall_ok = 1'b1;
    n = 0;
    while (!rk_valid_r && n < 40) begin
      if (key_ready_r || key_ready_c) stall_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    chk("stall_ready_low", 128'(stall_ok), 128'(1'b1));
    chk("zero_latency", 128'(n), 128'(13));
    chk("done_ready", 128'(key_ready_r), 128'(1'b1));
    chk("zero_rk2_first_done", rk_data_c, z_rk2);
    @(posedge clk); #1;
    key_valid = 1'b0;
    chk("reaccept_valid_low", 128'(rk_valid_r), 128'(1'b0));
    chk("zero_rk2_reg", rk_data_r, z_rk2);
    wait_valid(n);
    chk("reaccept_latency", 128'(n), 128'(13));
    chk("comb_variant_valid", 128'(rk_valid_c), 128'(1'b1));

    // Sweep rk_addr 0..15 on the FIPS-197 key.
    for (int a = 0; a < 16; a++) begin
      case (a)
        0:  rd(4'(a), a_rk0, "rk0");
        1:  rd(4'(a), a_rk1, "rk1");
        2:  rd(4'(a), a_rk2, "rk2");
        14: rd(4'(a), a_rk14, "rk14");
        15: rd(4'(a), '0, "rk15");
        default: begin
          rk_addr = 4'(a);
          @(posedge clk); #1;
        end
      endcase
    end
    // Registered port holds the old address's data until the next edge; comb port follows at once.
    rk_addr = 4'd0;
    #1;
    chk("lat_comb_now", rk_data_c, a_rk0);
    chk("lat_reg_hold", rk_data_r, '0);
    @(posedge clk); #1;
    chk("lat_reg_next", rk_data_r, a_rk0);

    // Zero-key schedule again for rk3, then reset mid-expansion.
    load('0);
    wait_valid(n);
    rd(4'd3, z_rk3, "zero_rk3");
    load('0);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("abort_busy", 128'(busy_r), 128'(1'b0));
    chk("abort_valid", 128'(rk_valid_r), 128'(1'b0));
    chk("abort_ready", 128'(key_ready_r), 128'(1'b1));
    #2 rst = 1'b0;
    @(posedge clk); #1;
    load(key_a);
    wait_valid(n);
    chk("reload_latency", 128'(n), 128'(13));
    rd(4'd14, a_rk14, "reload_rk14");

`ifdef AES_KEY_ZEROIZE_EN
    load(key_a);
    repeat (3) begin @(posedge clk); #1; end
    key_clear = 1'b1;
    @(posedge clk); #1;
    key_clear = 1'b0;
    chk("clr_busy", 128'(busy_r), 128'(1'b0));
    chk("clr_valid", 128'(rk_valid_r), 128'(1'b0));
    for (int a = 0; a < 15; a++) begin
      rk_addr = 4'(a);
      #1;
      chk("clr_zero", rk_data_c, '0);
    end
    key = key_a;
    key_valid = 1'b1;
    key_clear = 1'b1;
    #1;
    chk("clr_ready_low", 128'(key_ready_r), 128'(1'b0));
    @(posedge clk); #1;
    key_valid = 1'b0;
    key_clear = 1'b0;
    chk("clr_no_accept", 128'(busy_r), 128'(1'b0));
    rk_addr = 4'd0;
    #1;
    chk("clr_no_store", rk_data_c, '0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
